inverter_pipe: RTL and testbench
================================

// Module: inverter_pipe
// PURPOSE
//  Parametrised successor to the single-bit optional-delay inverter. Conditions a WIDTH-bit
//  bus: a runtime-writable mask selects which bits are inverted, then a DELAY-deep pipeline
//  with clock-enable stall carries data and a valid flag. Per-bit rise and fall detection runs
//  on the output. Used wherever control or flag buses need polarity fix-up plus latency matching.
// PARAMETERS
//  WIDTH        8               data width in bits, 1..64
//  DELAY        1               pipeline stages, 0..16; 0 = combinational data path
//  INVERT_MASK  {WIDTH{1'b1}}   reset value of the mask register; 1 = invert that bit
//  RESET_VALUE  {WIDTH{1'b0}}   reset value of the data stages and of last_data
// PORTS
//  clk       in   1      clock, rising edge
//  rst       in   1      synchronous reset, active-high
//  ce        in   1      clock enable; 0 = pipeline, valids and last_data hold
//  i_valid   in   1      input qualifier
//  i_data    in   WIDTH  input data
//  mask_we   in   1      mask write strobe (independent of ce)
//  mask_din  in   WIDTH  new mask value
//  mask_q    out  WIDTH  current mask register
//  o_valid   out  1      output qualifier
//  o_data    out  WIDTH  conditioned, delayed data
//  o_rise    out  WIDTH  per-bit 0->1 relative to previous valid output
//  o_fall    out  WIDTH  per-bit 1->0 relative to previous valid output
// BEHAVIOUR
//  - Reset (rst=1 at edge, overrides ce and mask_we): mask_q=INVERT_MASK; all stage valids=0;
//    stage data=RESET_VALUE; last_data=RESET_VALUE. Hence o_valid=0, o_rise=o_fall=0,
//    and o_data=RESET_VALUE when DELAY>=1.
//  - Conditioning: cond = i_data ^ mask_q, using the mask value before any write on the
//    same edge. A mask write takes effect for data sampled on the following edge.
//  - DELAY=0: o_data=cond and o_valid=i_valid, both combinational. Only the mask register
//    and last_data are sequential.
//  - DELAY>=1: shift chain of DELAY {valid,data} stages. On an edge with ce=1, stage0 loads
//    {i_valid,cond} and stage k loads stage k-1. On an edge with ce=0, all stages hold.
//    Outputs come from the last stage. Latency = DELAY edges with ce=1.
//  - Stage data loads regardless of valid. The valid bits alone qualify the contents; no
//    bubble collapsing.
//  - Edge detect: o_rise = {WIDTH{o_valid}} & o_data & ~last_data.
//    o_fall = {WIDTH{o_valid}} & ~o_data & last_data. Both combinational.
//    last_data<=o_data on an edge with ce=1 and o_valid=1. The first valid output after
//    reset is compared against RESET_VALUE.
//  - Invalid samples (o_valid=0) never update last_data and never produce edges.
//  - Reset mid-flight discards all in-flight samples. There is no flush output.
//  - A mask write during ce=0 still updates mask_q. It affects only samples entering after it.
//  - WIDTH outside 1..64 or DELAY outside 0..16 fails at elaboration via a generate-time error.
//  - WIDTH=1, DELAY=1, INVERT_MASK=1, ce=1, i_valid=1 reproduces the legacy delayed
//    inverter, except for reset.
// TESTING
//  1 Reset: hold rst 3 cycles with ce=1, i_valid=1 -> o_valid=0, o_rise=o_fall=0,
//    mask_q=INVERT_MASK, o_data=RESET_VALUE.
//  2 Latency: WIDTH=8, DELAY=3, mask 0xFF; drive 0x0F,0x55,0xA0 valid on consecutive
//    edges -> o_data 0xF0,0xAA,0x5F with o_valid=1 on edges 3,4,5.
//  3 Stall: same stream, ce=0 for 2 cycles mid-stream -> outputs hold, no sample lost or
//    duplicated; latency grows by exactly 2.
//  4 Mask write: mask_we=1, mask_din=0x0F with i_data=0x00 valid on the same edge ->
//    that sample exits as 0xFF (old mask); the next sample 0x00 exits as 0x0F.
//  5 Edges: DELAY=1, mask 0x00, valid inputs 0x00,0x81,0x80 -> o_rise=0x81 on the second
//    output, o_fall=0x01 on the third. An interleaved invalid beat changes nothing.
//  6 DELAY=0: i_data=0x3C, mask 0xFF -> o_data=0xC3 in the same cycle. Reset mid-stream
//    at DELAY=4 -> o_valid=0 on the next edge.

Source files
------------

// File: rtl/inverter_pipe.sv
// ============================================================================
// Module   : inverter_pipe
// Purpose  : Masked polarity fix-up of a WIDTH-bit bus, DELAY-deep stallable
//            pipeline with valid flag, and per-bit rise/fall detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inverter_pipe #(
    parameter int               WIDTH       = 8,
    parameter int               DELAY       = 1,
    parameter logic [WIDTH-1:0] INVERT_MASK = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             mask_we,
    input  logic [WIDTH-1:0] mask_din,
    output logic [WIDTH-1:0] mask_q,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    generate
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $error("inverter_pipe: WIDTH must be in 1..64");
        end
        if (DELAY < 0 || DELAY > 16) begin : g_bad_delay
            $error("inverter_pipe: DELAY must be in 0..16");
        end
    endgenerate

    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_last_data;
    logic [WIDTH-1:0] w_cond;

    // Conditioning uses the mask as it stood before any write on this edge.
    assign w_cond = i_data ^ r_mask;
    assign mask_q = r_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= INVERT_MASK;
        end else if (mask_we) begin
            r_mask <= mask_din;
        end
    end

    generate
        if (DELAY == 0) begin : g_comb
            assign o_valid = i_valid;
            assign o_data  = w_cond;
        end else begin : g_pipe
            logic [DELAY-1:0] r_vld;
            logic [WIDTH-1:0] r_dat [DELAY];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld <= '0;
                    for (int k = 0; k < DELAY; k++) begin
                        r_dat[k] <= RESET_VALUE;
                    end
                end else if (ce) begin
                    r_vld[0] <= i_valid;
                    r_dat[0] <= w_cond;
                    for (int k = 1; k < DELAY; k++) begin
                        r_vld[k] <= r_vld[k-1];
                        r_dat[k] <= r_dat[k-1];
                    end
                end
            end

            assign o_valid = r_vld[DELAY-1];
            assign o_data  = r_dat[DELAY-1];
        end
    endgenerate

    // Edge history advances only on accepted (ce) valid output samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_data <= RESET_VALUE;
        end else if (ce && o_valid) begin
            r_last_data <= o_data;
        end
    end

    assign o_rise = {WIDTH{o_valid}} &  o_data & ~r_last_data;
    assign o_fall = {WIDTH{o_valid}} & ~o_data &  r_last_data;

endmodule

`default_nettype wire

// File: tb/tb_inverter_pipe.sv
// ============================================================================
// Module   : tb_inverter_pipe
// Purpose  : Scoreboard bench for inverter_pipe at DELAY 3, 1, 0 and 4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inverter_pipe;

    typedef struct {
        logic [7:0] d;
        logic [7:0] r;
        logic [7:0] f;
        int         t;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    logic rst = 1'b1;
    logic rst4 = 1'b1;

    // DELAY=3, mask 0xFF
    logic ce3 = 1'b1, iv3 = 1'b1, mwe3 = 1'b0;
    logic [7:0] id3 = 8'hAA, mdin3 = 8'h00;
    logic [7:0] mq3, od3, or3, of3;
    logic ov3;
    // DELAY=1, mask 0x00
    logic ce1 = 1'b1, iv1 = 1'b1, mwe1 = 1'b0;
    logic [7:0] id1 = 8'hAA, mdin1 = 8'h00;
    logic [7:0] mq1, od1, or1, of1;
    logic ov1;
    // DELAY=0, mask 0xFF
    logic ce0 = 1'b1, iv0 = 1'b1, mwe0 = 1'b0;
    logic [7:0] id0 = 8'hAA, mdin0 = 8'h00;
    logic [7:0] mq0, od0, or0, of0;
    logic ov0;
    // DELAY=4, mask 0xFF
    logic ce4 = 1'b1, iv4 = 1'b1, mwe4 = 1'b0;
    logic [7:0] id4 = 8'hAA, mdin4 = 8'h00;
    logic [7:0] mq4, od4, or4, of4;
    logic ov4;

    inverter_pipe #(.WIDTH(8), .DELAY(3), .INVERT_MASK(8'hFF), .RESET_VALUE(8'h00)) u_d3 (
        .clk(clk), .rst(rst), .ce(ce3), .i_valid(iv3), .i_data(id3), .mask_we(mwe3),
        .mask_din(mdin3), .mask_q(mq3), .o_valid(ov3), .o_data(od3), .o_rise(or3), .o_fall(of3));
    inverter_pipe #(.WIDTH(8), .DELAY(1), .INVERT_MASK(8'h00), .RESET_VALUE(8'h00)) u_d1 (
        .clk(clk), .rst(rst), .ce(ce1), .i_valid(iv1), .i_data(id1), .mask_we(mwe1),
        .mask_din(mdin1), .mask_q(mq1), .o_valid(ov1), .o_data(od1), .o_rise(or1), .o_fall(of1));
    inverter_pipe #(.WIDTH(8), .DELAY(0), .INVERT_MASK(8'hFF), .RESET_VALUE(8'h00)) u_d0 (
        .clk(clk), .rst(rst), .ce(ce0), .i_valid(iv0), .i_data(id0), .mask_we(mwe0),
        .mask_din(mdin0), .mask_q(mq0), .o_valid(ov0), .o_data(od0), .o_rise(or0), .o_fall(of0));
    inverter_pipe #(.WIDTH(8), .DELAY(4), .INVERT_MASK(8'hFF), .RESET_VALUE(8'h00)) u_d4 (
        .clk(clk), .rst(rst4), .ce(ce4), .i_valid(iv4), .i_data(id4), .mask_we(mwe4),
        .mask_din(mdin4), .mask_q(mq4), .o_valid(ov4), .o_data(od4), .o_rise(or4), .o_fall(of4));

    // Scoreboards: expected outputs plus the ce-edge count at which each must appear
    exp_t q3[$];
    exp_t q1[$];
    exp_t e3, e1;
    logic [7:0] prev3 = 8'h00, prev1 = 8'h00;
    int   cnt3 = 0, cnt1 = 0;
    logic adv3 = 1'b0, adv1 = 1'b0;
    logic [7:0] held3 = 8'h00, held1 = 8'h00;

    always @(posedge clk) begin
        if (ce3) cnt3 <= cnt3 + 1;
        if (ce1) cnt1 <= cnt1 + 1;
        adv3 <= ce3 && !rst;
        adv1 <= ce1 && !rst;
    end

    always @(negedge clk) begin
        if (ov3 && adv3) begin
            if (q3.size() == 0) begin
                chk("d3_unexpected_output", {56'd0, od3}, 64'hDEAD);
            end else begin
                e3 = q3.pop_front();
                chk("d3_data", {56'd0, od3}, {56'd0, e3.d});
                chk("d3_rise", {56'd0, or3}, {56'd0, e3.r});
                chk("d3_fall", {56'd0, of3}, {56'd0, e3.f});
                chk("d3_latency_ce_edges", 64'(cnt3), 64'(e3.t));
            end
        end else if (ov3) begin
            chk("d3_stall_hold", {56'd0, od3}, {56'd0, held3});
        end else begin
            chk("d3_no_edges_when_invalid", {48'd0, or3, of3}, 64'd0);
        end
        held3 = od3;
    end

    always @(negedge clk) begin
        if (ov1 && adv1) begin
            if (q1.size() == 0) begin
                chk("d1_unexpected_output", {56'd0, od1}, 64'hDEAD);
            end else begin
                e1 = q1.pop_front();
                chk("d1_data", {56'd0, od1}, {56'd0, e1.d});
                chk("d1_rise", {56'd0, or1}, {56'd0, e1.r});
                chk("d1_fall", {56'd0, of1}, {56'd0, e1.f});
                chk("d1_latency_ce_edges", 64'(cnt1), 64'(e1.t));
            end
        end else if (ov1) begin
            chk("d1_stall_hold", {56'd0, od1}, {56'd0, held1});
        end else begin
            chk("d1_no_edges_when_invalid", {48'd0, or1, of1}, 64'd0);
        end
        held1 = od1;
    end

    // exp is the hand-computed conditioned value; rise/fall follow from the previous valid output
    task automatic issue3(input logic [7:0] d, input logic [7:0] exp,
                          input logic we, input logic [7:0] din);
        exp_t it;
        @(posedge clk); #1;
        ce3 = 1'b1; iv3 = 1'b1; id3 = d; mwe3 = we; mdin3 = din;
        it.d = exp; it.r = exp & ~prev3; it.f = ~exp & prev3; it.t = cnt3 + 3;
        q3.push_back(it);
        prev3 = exp;
    endtask

    task automatic idle3(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            ce3 = 1'b1; iv3 = 1'b0; id3 = 8'h00; mwe3 = 1'b0;
        end
    endtask

    // Stall with junk valid data offered; optional mask write on the first stalled edge
    task automatic stall3(input int n, input logic we, input logic [7:0] din);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            ce3 = 1'b0; iv3 = 1'b1; id3 = 8'hEE;
            mwe3 = (i == 0) ? we : 1'b0; mdin3 = din;
        end
    endtask

    task automatic issue1(input logic [7:0] d, input logic v, input logic [7:0] exp);
        exp_t it;
        @(posedge clk); #1;
        ce1 = 1'b1; iv1 = v; id1 = d;
        if (v) begin
            it.d = exp; it.r = exp & ~prev1; it.f = ~exp & prev1; it.t = cnt1 + 1;
            q1.push_back(it);
            prev1 = exp;
        end
    endtask

    task automatic idle1(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            ce1 = 1'b1; iv1 = 1'b0; id1 = 8'h00;
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset held three edges with ce=1 and valid input
        repeat (3) @(posedge clk);
        #1;
        chk("rst_d3_valid", {63'd0, ov3}, 64'd0);
        chk("rst_d3_data", {56'd0, od3}, 64'h00);
        chk("rst_d3_edges", {48'd0, or3, of3}, 64'd0);
        chk("rst_d3_mask", {56'd0, mq3}, 64'hFF);
        chk("rst_d1_mask", {56'd0, mq1}, 64'h00);
        chk("rst_d0_mask", {56'd0, mq0}, 64'hFF);
        chk("rst_d4_valid", {63'd0, ov4}, 64'd0);
        rst = 1'b0; rst4 = 1'b0;
        iv3 = 1'b0; iv1 = 1'b0; iv0 = 1'b0; iv4 = 1'b0;

        // Latency through DELAY=3
        issue3(8'h0F, 8'hF0, 1'b0, 8'h00);
        issue3(8'h55, 8'hAA, 1'b0, 8'h00);
        issue3(8'hA0, 8'h5F, 1'b0, 8'h00);
        idle3(4);
        // Two-cycle stall mid-stream
        issue3(8'h0F, 8'hF0, 1'b0, 8'h00);
        issue3(8'h55, 8'hAA, 1'b0, 8'h00);
        stall3(2, 1'b0, 8'h00);
        issue3(8'hA0, 8'h5F, 1'b0, 8'h00);
        idle3(4);
        // Mask write on the same edge as a sample: old mask applies to it
        issue3(8'h00, 8'hFF, 1'b1, 8'h0F);
        issue3(8'h00, 8'h0F, 1'b0, 8'h00);
        idle3(1);
        chk("d3_mask_after_write", {56'd0, mq3}, 64'h0F);
        idle3(3);
        // Mask write while stalled
        issue3(8'h3C, 8'h33, 1'b0, 8'h00);
        stall3(1, 1'b1, 8'hF0);
        issue3(8'h3C, 8'hCC, 1'b0, 8'h00);
        idle3(5);
        chk("d3_mask_write_in_stall", {56'd0, mq3}, 64'hF0);

        // Edge detection at DELAY=1 with an interleaved invalid beat
        issue1(8'h00, 1'b1, 8'h00);
        issue1(8'h81, 1'b1, 8'h81);
        issue1(8'hFF, 1'b0, 8'h00);
        issue1(8'h80, 1'b1, 8'h80);
        idle1(3);

        // DELAY=0 combinational path
        @(posedge clk); #1;
        ce0 = 1'b1; iv0 = 1'b1; id0 = 8'h3C; #1;
        chk("d0_data", {56'd0, od0}, 64'hC3);
        chk("d0_valid", {63'd0, ov0}, 64'd1);
        chk("d0_rise_first", {56'd0, or0}, 64'hC3);
        chk("d0_fall_first", {56'd0, of0}, 64'h00);
        @(posedge clk); #1;
        chk("d0_rise_repeat", {48'd0, or0, of0}, 64'd0);
        id0 = 8'hC3; #1;
        chk("d0_data_b", {56'd0, od0}, 64'h3C);
        chk("d0_rise_b", {56'd0, or0}, 64'h3C);
        chk("d0_fall_b", {56'd0, of0}, 64'hC3);
        iv0 = 1'b0; #1;
        chk("d0_invalid_valid", {63'd0, ov0}, 64'd0);
        chk("d0_invalid_edges", {48'd0, or0, of0}, 64'd0);
        @(posedge clk); #1;
        iv0 = 1'b1; id0 = 8'h3C; ce0 = 1'b0; #1;
        chk("d0_invalid_kept_last", {48'd0, or0, of0}, 64'd0);
        @(posedge clk); #1;
        id0 = 8'hC3; #1;
        chk("d0_ce_hold_rise", {56'd0, or0}, 64'h3C);
        chk("d0_ce_hold_fall", {56'd0, of0}, 64'hC3);
        iv0 = 1'b0; ce0 = 1'b1;

        // Reset mid-flight at DELAY=4 discards every in-flight sample
        @(posedge clk); #1; ce4 = 1'b1; iv4 = 1'b1; id4 = 8'h11;
        @(posedge clk); #1; id4 = 8'h22;
        @(posedge clk); #1; id4 = 8'h33;
        @(posedge clk); #1; iv4 = 1'b0; rst4 = 1'b1;
        @(posedge clk); #1;
        chk("d4_valid_after_reset", {63'd0, ov4}, 64'd0);
        chk("d4_data_after_reset", {56'd0, od4}, 64'h00);
        rst4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("d4_no_survivor", {63'd0, ov4}, 64'd0);
        end

        chk("d3_queue_drained", 64'(q3.size()), 64'd0);
        chk("d1_queue_drained", 64'(q1.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
